// File: rtl/serial_pkg.sv
// Shared types for the serial comparator datapath: shifter FSM states,
// frame bit-order constants and the bit-counter width helper.
package serial_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic ORDER_LSB = 1'b0;
  localparam logic ORDER_MSB = 1'b1;

  // Counter must index WIDTH bits; a 1-bit operand still gets a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_pair_serializer_if.sv
// Operand-pair input and serial bit-pair output channels of the serializer.
// Handshake: a beat moves on a rising clk edge where valid & ready are both
// high; a producer holds valid and payload stable until that edge.
interface serial_pair_serializer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_msb_first;
  logic             out_valid;
  logic             out_ready;
  logic             out_a;
  logic             out_b;
  logic             out_first;
  logic             out_last;

  modport master (
    output in_valid, in_a, in_b, in_msb_first, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_first, out_last
  );

  modport slave (
    input  in_valid, in_a, in_b, in_msb_first, out_ready,
    output in_ready, out_valid, out_a, out_b, out_first, out_last
  );
endinterface

// File: rtl/serial_pair_shifter.sv
// Twin shift registers plus frame order bit and bit counter. load wins over
// advance; the outgoing bit sits at the end selected by the frame order.
module serial_pair_shifter
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [WIDTH-1:0] ld_a,
  input  logic [WIDTH-1:0] ld_b,
  input  logic             ld_order,
  output logic             out_a,
  output logic             out_b,
  output logic [CW-1:0]    cnt
);

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             order;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a  <= '0;
      sh_b  <= '0;
      order <= ORDER_LSB;
      cnt   <= '0;
    end else if (load) begin
      sh_a  <= ld_a;
      sh_b  <= ld_b;
      order <= ld_order;
      cnt   <= '0;
    end else if (advance) begin
      if (order == ORDER_MSB) begin
        sh_a <= sh_a << 1;
        sh_b <= sh_b << 1;
      end else begin
        sh_a <= sh_a >> 1;
        sh_b <= sh_b >> 1;
      end
      cnt <= cnt + CW'(1);
    end
  end

  assign out_a = (order == ORDER_MSB) ? sh_a[WIDTH-1] : sh_a[0];
  assign out_b = (order == ORDER_MSB) ? sh_b[WIDTH-1] : sh_b[0];

endmodule

// File: rtl/serial_pair_serializer.sv
// Parallel-to-serial transmitter: one pending operand pair buffered ahead of
// the shifter so back-to-back frames stream without a gap.
module serial_pair_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  serial_pair_serializer_if.slave   bus,
  output state_t                    dbg_state
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic             pend_full;
  logic [WIDTH-1:0] pend_a;
  logic [WIDTH-1:0] pend_b;
  logic             pend_order;
  logic             accept;
  logic             load;
  logic             advance;
  logic             pend_take;
  logic             shifting;
  logic [CW-1:0]    cnt;

  // in_ready depends only on rst and registered state, never on out_ready.
  assign bus.in_ready = ~rst & ~pend_full;
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_full  <= 1'b0;
      pend_a     <= '0;
      pend_b     <= '0;
      pend_order <= ORDER_LSB;
    end else if (accept) begin
      pend_full  <= 1'b1;
      pend_a     <= bus.in_a;
      pend_b     <= bus.in_b;
      pend_order <= bus.in_msb_first;
    end else if (pend_take) begin
      pend_full  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    advance   = 1'b0;
    pend_take = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend_full) begin
          load      = 1'b1;
          pend_take = 1'b1;
          state_nx  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.out_ready) begin
          if (cnt != LAST) begin
            advance = 1'b1;
          end else if (pend_full) begin
            // Final bit leaves while the next pair is waiting: no idle cycle.
            load      = 1'b1;
            pend_take = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  serial_pair_shifter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .advance  (advance),
    .ld_a     (pend_a),
    .ld_b     (pend_b),
    .ld_order (pend_order),
    .out_a    (bus.out_a),
    .out_b    (bus.out_b),
    .cnt      (cnt)
  );

  assign shifting      = (state == ST_SHIFT);
  assign bus.out_valid = shifting;
  assign bus.out_first = shifting & (cnt == '0);
  assign bus.out_last  = shifting & (cnt == LAST);
  assign dbg_state     = state;

endmodule

// File: tb/tb_serial_pair_serializer.sv
// Bench for serial_pair_serializer: directed frames, back-to-back, stalls,
// mid-frame reset and randomized frames against a behavioural model.
module tb_serial_pair_serializer;
  import serial_pkg::*;

  localparam int W = 8;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;
  int     tests = 0;
  int     fails = 0;
  logic [3:0] exp_q[$];  // {a_bit, b_bit, first, last} per transfer

  serial_pair_serializer_if #(.WIDTH(W)) bus ();

  serial_pair_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Element i is the i-th bit on the wire for value v in the given order.
  function automatic logic [W-1:0] ser_bits(input logic [W-1:0] v, input logic msb);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = msb ? v[W-1-i] : v[i];
    return r;
  endfunction

  function automatic void push_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic msb);
    logic [W-1:0] sa;
    logic [W-1:0] sb;
    sa = ser_bits(a, msb);
    sb = ser_bits(b, msb);
    for (int i = 0; i < W; i++)
      exp_q.push_back({sa[i], sb[i], (i == 0), (i == W - 1)});
  endfunction

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b, input logic msb);
    int guard;
    guard            = 0;
    bus.in_valid     = 1'b1;
    bus.in_a         = a;
    bus.in_b         = b;
    bus.in_msb_first = msb;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_pair: in_ready stayed %b, required 1 within 50 cycles", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Returns the received stream, the latency in cycles after the accept edge
  // and the number of bits captured.
  task automatic collect_frame(input int stall_pct,
                               output logic [W-1:0] ga, output logic [W-1:0] gb,
                               output logic [W-1:0] gf, output logic [W-1:0] gl,
                               output int lat, output int n);
    int guard;
    ga = '0; gb = '0; gf = '0; gl = '0;
    lat = 1; n = 0; guard = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    while (n < W && guard < 400) begin
      bus.out_ready = ($urandom_range(99) >= stall_pct);
      if (bus.out_valid && bus.out_ready) begin
        ga[n] = bus.out_a; gb[n] = bus.out_b;
        gf[n] = bus.out_first; gl[n] = bus.out_last;
        n++;
      end
      @(negedge clk);
      guard++;
    end
    bus.out_ready = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.in_msb_first = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.out_a, bus.out_b, bus.out_first, bus.out_last} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b, required 00000",
               {bus.out_valid, bus.out_a, bus.out_b, bus.out_first, bus.out_last});
    end
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++; $display("FAIL reset_in_ready: got %b, required 0", bus.in_ready);
    end
    tests++;
    if (dbg_state !== ST_IDLE) begin
      fails++; $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL post_reset: in_ready=%b out_valid=%b, required 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_frame(input logic msb, input logic [W-1:0] lit_a, input logic [W-1:0] lit_b);
    logic [W-1:0] ga, gb, gf, gl;
    int lat, n;
    send_pair(8'hC1, 8'h3C, msb);
    collect_frame(0, ga, gb, gf, gl, lat, n);
    tests++;
    if (lat !== 2 || n !== W) begin
      fails++; $display("FAIL frame_latency msb=%b: lat=%0d bits=%0d, required 2 %0d", msb, lat, n, W);
    end
    tests++;
    if (ga !== ser_bits(8'hC1, msb) || gb !== ser_bits(8'h3C, msb)) begin
      fails++;
      $display("FAIL frame_model msb=%b: a=%b b=%b, required %b %b", msb, ga, gb,
               ser_bits(8'hC1, msb), ser_bits(8'h3C, msb));
    end
    tests++;
    if (ga !== lit_a || gb !== lit_b) begin
      fails++; $display("FAIL frame_literal msb=%b: a=%b b=%b, required %b %b", msb, ga, gb, lit_a, lit_b);
    end
    tests++;
    if (gf !== 8'h01 || gl !== 8'h80) begin
      fails++; $display("FAIL frame_markers msb=%b: first=%b last=%b, required 00000001 10000000", msb, gf, gl);
    end
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL frame_idle msb=%b: out_valid=%b, required 0", msb, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]   pa[2];
    logic [W-1:0]   pb[2];
    logic [2*W-1:0] ga, gb, gf, gl, ea, eb;
    int  idx, n, cyc, first_cyc, last_cyc;
    bit  saw_block, acc_now;
    pa[0] = 8'hC1; pb[0] = 8'h3C; pa[1] = 8'h01; pb[1] = 8'h80;
    ga = '0; gb = '0; gf = '0; gl = '0;
    idx = 0; n = 0; cyc = 0; first_cyc = -1; last_cyc = -1; saw_block = 0;
    bus.out_ready = 1'b1; bus.in_msb_first = 1'b1;
    bus.in_valid = 1'b1; bus.in_a = pa[0]; bus.in_b = pb[0];
    while (n < 2 * W && cyc < 60) begin
      if (bus.out_valid) begin
        ga[n] = bus.out_a; gb[n] = bus.out_b; gf[n] = bus.out_first; gl[n] = bus.out_last;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        n++;
      end
      if (bus.in_valid && !bus.in_ready && idx == 1) saw_block = 1;
      acc_now = bus.in_valid && bus.in_ready;
      @(negedge clk);
      cyc++;
      if (acc_now) begin
        idx++;
        if (idx < 2) begin
          bus.in_a = pa[idx]; bus.in_b = pb[idx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    ea = {ser_bits(pa[1], 1'b1), ser_bits(pa[0], 1'b1)};
    eb = {ser_bits(pb[1], 1'b1), ser_bits(pb[0], 1'b1)};
    tests++;
    if (n !== 2 * W || (last_cyc - first_cyc) !== 2 * W - 1) begin
      fails++;
      $display("FAIL b2b_contiguous: bits=%0d span=%0d, required 16 15", n, last_cyc - first_cyc);
    end
    tests++;
    if (ga !== ea || gb !== eb) begin
      fails++; $display("FAIL b2b_data: a=%h b=%h, required %h %h", ga, gb, ea, eb);
    end
    tests++;
    if (gf !== 16'h0101 || gl !== 16'h8080) begin
      fails++; $display("FAIL b2b_markers: first=%h last=%h, required 0101 8080", gf, gl);
    end
    tests++;
    if (saw_block !== 1'b1) begin
      fails++; $display("FAIL b2b_in_ready_drop: saw_block=%b, required 1", saw_block);
    end
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_idle: out_valid=%b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, ga, gb, gf, gl;
    logic [3:0]   snap, cur;
    int i, stall, guard;
    a = W'($urandom); b = W'($urandom);
    ga = '0; gb = '0; gf = '0; gl = '0;
    i = 0; stall = 0; guard = 0; snap = '0;
    send_pair(a, b, 1'b1);
    while (i < W && guard < 100) begin
      cur = {bus.out_a, bus.out_b, bus.out_first, bus.out_last};
      if (bus.out_valid && i == 4 && stall < 3) begin
        bus.out_ready = 1'b0;
        if (stall == 0) begin
          snap = cur;
        end else begin
          tests++;
          if (cur !== snap) begin
            fails++; $display("FAIL stall_hold cycle %0d: got %b, required %b", stall, cur, snap);
          end
        end
        stall++;
      end else begin
        bus.out_ready = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        ga[i] = bus.out_a; gb[i] = bus.out_b; gf[i] = bus.out_first; gl[i] = bus.out_last;
        i++;
      end
      @(negedge clk);
      guard++;
    end
    bus.out_ready = 1'b1;
    tests++;
    if (stall !== 3 || ga !== ser_bits(a, 1'b1) || gb !== ser_bits(b, 1'b1)) begin
      fails++;
      $display("FAIL stall_stream: stalls=%0d a=%b b=%b, required 3 %b %b", stall, ga, gb,
               ser_bits(a, 1'b1), ser_bits(b, 1'b1));
    end
    tests++;
    if (gf !== 8'h01 || gl !== 8'h80) begin
      fails++; $display("FAIL stall_markers: first=%b last=%b, required 00000001 10000000", gf, gl);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] ga, gb, gf, gl;
    int  lat, n;
    bit  saw_valid;
    send_pair(8'hA5, 8'h5A, 1'b1);
    send_pair(8'hFF, 8'hFF, 1'b1);
    repeat (2) @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_first !== 1'b0) begin
      fails++; $display("FAIL midrst_pre: out_valid=%b first=%b, required 1 0", bus.out_valid, bus.out_first);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL midrst_async: out_valid=%b in_ready=%b state=%0d, required 0 0 0",
               bus.out_valid, bus.in_ready, dbg_state);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    saw_valid = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) saw_valid = 1;
    end
    tests++;
    if (saw_valid !== 1'b0) begin
      fails++; $display("FAIL midrst_silent: saw out_valid=%b, required 0", saw_valid);
    end
    send_pair(8'h3C, 8'hC3, 1'b0);
    collect_frame(0, ga, gb, gf, gl, lat, n);
    tests++;
    if (lat !== 2 || ga !== ser_bits(8'h3C, 1'b0) || gb !== ser_bits(8'hC3, 1'b0)) begin
      fails++;
      $display("FAIL midrst_fresh: lat=%0d a=%b b=%b, required 2 %b %b", lat, ga, gb,
               ser_bits(8'h3C, 1'b0), ser_bits(8'hC3, 1'b0));
    end
  endtask

  // Random pairs and order with random stalls; MSB-first frames also run a
  // serial magnitude comparison over the received bits.
  task automatic test_random_compare();
    logic [W-1:0] a, b;
    logic [3:0]   exp, got;
    logic         msb, lt, gt, decided;
    int  guard, bad_bits, verdict_bad;
    bad_bits = 0; verdict_bad = 0;
    for (int it = 0; it < 1000; it++) begin
      a   = W'($urandom_range(0, 255));
      b   = ($urandom_range(0, 3) == 0) ? a : W'($urandom_range(0, 255));
      msb = ($urandom_range(0, 2) != 0);
      push_frame(a, b, msb);
      send_pair(a, b, msb);
      lt = 0; gt = 0; decided = 0; guard = 0;
      while (exp_q.size() > 0 && guard < 200) begin
        bus.out_ready = ($urandom_range(99) >= 25);
        if (bus.out_valid && bus.out_ready) begin
          exp = exp_q.pop_front();
          got = {bus.out_a, bus.out_b, bus.out_first, bus.out_last};
          if (got !== exp) bad_bits++;
          if (!decided && bus.out_a !== bus.out_b) begin
            decided = 1; gt = bus.out_a; lt = bus.out_b;
          end
          if (bus.out_last && msb) begin
            tests++;
            if ({lt, !(lt || gt), gt} !== {a < b, a == b, a > b}) begin
              fails++; verdict_bad++;
              $display("FAIL cmp_verdict a=%h b=%h: lt/eq/gt=%b, required %b", a, b,
                       {lt, !(lt || gt), gt}, {a < b, a == b, a > b});
            end
          end
        end
        @(negedge clk);
        guard++;
      end
      bus.out_ready = 1'b1;
      tests++;
      if (exp_q.size() !== 0 || bad_bits !== 0) begin
        fails++;
        $display("FAIL rand_frame a=%h b=%h msb=%b: left=%0d bad_bits=%0d, required 0 0",
                 a, b, msb, exp_q.size(), bad_bits);
        exp_q.delete();
        bad_bits = 0;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_frame(1'b1, 8'b1000_0011, 8'b0011_1100);
    test_frame(1'b0, 8'b1100_0001, 8'b0011_1100);
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    test_random_compare();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
